program_loader: RTL and testbench

- Writer side of the program-memory interface: the CPU only reads instruction words from program memory, and this block is what fills that memory.
- Receives a framed byte stream over a valid/ready handshake (from the serial receiver) and assembles big-endian 16-bit instruction words.
- Writes the words into program memory from address 0 upward, then verifies a trailing XOR checksum.
- Holds the CPU (cpu_hold, OR-ed into the CPU reset path) for the whole load.

---
 rtl/program_loader_pkg.sv | 30 +++
 rtl/loader_byte_assembler.sv | 66 ++++++
 rtl/program_loader.sv | 149 ++++++++++++++
 tb/tb_program_loader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// program_loader_pkg
//   Shared definitions for the program-memory loader: loader FSM state
//   encoding, frame layout constants and the program memory geometry that
//   the loader, the CPU program counter and the memory must agree on.
package program_loader_pkg;

    // Program memory geometry (12-bit PC, 16-bit instruction words).
    localparam int ADDR_W     = 12;
    localparam int WORD_BYTES = 2;
    localparam int DATA_W     = 8 * WORD_BYTES;
    localparam int MAX_WORDS  = 2 ** ADDR_W;

    // Frame layout.
    localparam int          LEN_BYTES = 2;
    localparam int          LEN_W     = 8 * LEN_BYTES;
    localparam logic [7:0]  CSUM_OK   = 8'h00;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LEN_HI  = 4'd1,
        ST_LEN_LO  = 4'd2,
        ST_DATA_HI = 4'd3,
        ST_DATA_LO = 4'd4,
        ST_WRITE   = 4'd5,
        ST_CSUM    = 4'd6,
        ST_DONE    = 4'd7,
        ST_ERROR   = 4'd8
    } loader_state_e;

endpackage

// File: rtl/loader_byte_assembler.sv
// loader_byte_assembler
//   Byte-level datapath of the program loader. Latches the high and low
//   byte of each big-endian word and keeps the running XOR of every byte
//   transferred in the current frame.
//   Ports:
//     clk, reset   - clock, asynchronous active-low reset
//     clear        - restart the XOR accumulator (start of a new frame)
//     accept       - a byte is transferred this cycle
//     is_hi        - the accepted byte is the high byte of a pair
//     byte_i       - the byte being transferred
//     hi_o         - last latched high byte
//     word_o       - {high, low} assembled word
//     csum_ok_o    - accumulator XOR byte_i equals the frame-good value
module loader_byte_assembler
    import program_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              accept,
    input  logic              is_hi,
    input  logic [7:0]        byte_i,
    output logic [7:0]        hi_o,
    output logic [DATA_W-1:0] word_o,
    output logic              csum_ok_o
);

    logic [7:0] hi_q, hi_d;
    logic [7:0] lo_q, lo_d;
    logic [7:0] acc_q, acc_d;

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        acc_d = acc_q;
        if (clear) begin
            acc_d = 8'h00;
        end else if (accept) begin
            acc_d = acc_q ^ byte_i;
            if (is_hi) begin
                hi_d = byte_i;
            end else begin
                lo_d = byte_i;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q  <= 8'h00;
            lo_q  <= 8'h00;
            acc_q <= 8'h00;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            acc_q <= acc_d;
        end
    end

    assign hi_o      = hi_q;
    assign word_o    = {hi_q, lo_q};
    // Evaluated against the byte on the wire so the checksum byte itself
    // is folded in on the cycle it is transferred.
    assign csum_ok_o = ((acc_q ^ byte_i) == CSUM_OK);

endmodule

// File: rtl/program_loader.sv
// program_loader
//   Fills program memory from a framed byte stream:
//     LEN_HI LEN_LO, N x (WORD_HI WORD_LO), CSUM
//   Words are written from address 0 upward; the frame is accepted only if
//   the XOR of all its bytes is zero. The CPU is held in reset for the
//   whole load and stays held if the load fails.
//   Ports:
//     clk, reset         - clock, asynchronous active-low reset
//     start              - one-cycle pulse, begins a load from IDLE/DONE/ERROR
//     rx_data/valid/ready- byte stream handshake (transfer = valid && ready)
//     mem_address/mem_data_in/mem_write_enable - program memory write port
//     cpu_hold           - keep CPU in reset
//     busy, done, error  - load status (done/error sticky until next start)
//     words_loaded       - words written in the current or last load
module program_loader #(
    parameter int ADDR_W    = program_loader_pkg::ADDR_W,
    parameter int DATA_W    = program_loader_pkg::DATA_W,
    parameter int MAX_WORDS = program_loader_pkg::MAX_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write_enable,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    import program_loader_pkg::*;

    localparam logic [LEN_W:0]    MAX_N    = (LEN_W + 1)'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W - 1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [ADDR_W:0]   len_q, len_d;

    logic              transfer;
    logic              asm_clear;
    logic              asm_is_hi;
    logic [7:0]        asm_hi;
    logic              csum_ok;
    logic [LEN_W-1:0]  len_word;
    logic [ADDR_W:0]   words_inc;

    // rx_ready is a pure decode of the registered state.
    assign rx_ready  = (state_q == ST_LEN_HI)  || (state_q == ST_LEN_LO) ||
                       (state_q == ST_DATA_HI) || (state_q == ST_DATA_LO) ||
                       (state_q == ST_CSUM);
    assign transfer  = rx_valid && rx_ready;
    assign asm_is_hi = (state_q == ST_LEN_HI) || (state_q == ST_DATA_HI);
    assign len_word  = {asm_hi, rx_data};
    assign words_inc = words_q + CNT_ONE;

    loader_byte_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear),
        .accept    (transfer),
        .is_hi     (asm_is_hi),
        .byte_i    (rx_data),
        .hi_o      (asm_hi),
        .word_o    (mem_data_in),
        .csum_ok_o (csum_ok)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        words_d   = words_q;
        len_d     = len_q;
        asm_clear = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d   = ST_LEN_HI;
                    addr_d    = '0;
                    words_d   = '0;
                    asm_clear = 1'b1;
                end
            end
            ST_LEN_HI: begin
                if (transfer) state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (transfer) begin
                    len_d = len_word[ADDR_W:0];
                    if ({1'b0, len_word} > MAX_N) begin
                        state_d = ST_ERROR;
                    end else if (len_word == '0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (transfer) state_d = ST_DATA_LO;
            end
            ST_DATA_LO: begin
                if (transfer) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                // After the last word of a full 4096-word image addr wraps
                // to 0, but it is never used again before the next start.
                addr_d  = addr_q + ADDR_ONE;
                words_d = words_inc;
                state_d = (words_inc == len_q) ? ST_CSUM : ST_DATA_HI;
            end
            ST_CSUM: begin
                if (transfer) state_d = csum_ok ? ST_DONE : ST_ERROR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            words_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            len_q   <= len_d;
        end
    end

    assign mem_address      = addr_q;
    assign mem_write_enable = (state_q == ST_WRITE);
    assign busy             = rx_ready || (state_q == ST_WRITE);
    // A failed image must never be released to the CPU.
    assign cpu_hold         = busy || (state_q == ST_ERROR);
    assign done             = (state_q == ST_DONE);
    assign error            = (state_q == ST_ERROR);
    assign words_loaded     = words_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [11:0] mem_address;
    logic [15:0] mem_data_in;
    logic        mem_write_enable;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [12:0] words_loaded;

    int checks = 0;
    int passes = 0;

    logic [11:0] wr_addr[$];
    logic [15:0] wr_data[$];
    int          ready_in_write = 0;
    logic [7:0]  frame[$];

    program_loader dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .mem_address      (mem_address),
        .mem_data_in      (mem_data_in),
        .mem_write_enable (mem_write_enable),
        .cpu_hold         (cpu_hold),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .words_loaded     (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-port monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset && mem_write_enable) begin
            wr_addr.push_back(mem_address);
            wr_data.push_back(mem_data_in);
            $display("write addr=%0d data=%h", mem_address, mem_data_in);
            if (rx_ready) ready_in_write++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        ready_in_write = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte after 'gap' idle cycles and wait for it to be taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit sent;
        sent = 1'b0;
        @(negedge clk);
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (rx_ready) begin
                @(posedge clk);
                #1;
                sent = 1'b1;
                break;
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        checks++;
        if (!sent)
            $display("FAIL byte_accept: byte %h not taken, got rx_ready=%b required 1", b, rx_ready);
        else
            passes++;
        $display("byte %h sent", b);
    endtask

    task automatic send_frame(input int max_gap);
        for (int i = 0; i < frame.size(); i++)
            send_byte(frame[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++;
        if ({rx_ready, mem_write_enable, cpu_hold, busy, done, error} !== 6'b0)
            $display("FAIL reset_flags: got %b required 000000",
                     {rx_ready, mem_write_enable, cpu_hold, busy, done, error});
        else passes++;
        @(negedge clk);
        reset = 1'b1;
        clear_log();
        pulse_start();
        frame = '{8'h00, 8'h02, 8'h12, 8'h34};
        send_frame(0);
        @(negedge clk);   // WRITE cycle
        @(negedge clk);   // now waiting for next word
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({rx_ready, mem_write_enable, cpu_hold, busy, done, error} !== 6'b0)
            $display("FAIL midload_reset_flags: got %b required 000000",
                     {rx_ready, mem_write_enable, cpu_hold, busy, done, error});
        else passes++;
        checks++;
        if (words_loaded !== 13'd0 || mem_address !== 12'd0 || mem_data_in !== 16'h0000)
            $display("FAIL midload_reset_regs: got words=%0d addr=%0d data=%h required 0 0 0000",
                     words_loaded, mem_address, mem_data_in);
        else passes++;
        checks++;
        if (dut.state_q !== program_loader_pkg::ST_IDLE)
            $display("FAIL midload_reset_state: got %0d required IDLE(0)", dut.state_q);
        else passes++;
        checks++;
        if (wr_addr.size() !== 1 || wr_addr[0] !== 12'd0 || wr_data[0] !== 16'h1234)
            $display("FAIL midload_reset_writes: got count=%0d required one write 0:1234", wr_addr.size());
        else passes++;
        @(negedge clk);
        reset = 1'b1;
        $display("test_reset done");
    endtask

    // XOR of 00 02 12 34 AB CD is 8'h42, so 8'h42 is the good checksum.
    task automatic test_good_load(input int max_gap, input string tag);
        clear_log();
        pulse_start();
        checks++;
        if ({busy, cpu_hold, rx_ready, done, error} !== 5'b11100)
            $display("FAIL %s_start_status: got %b required 11100", tag,
                     {busy, cpu_hold, rx_ready, done, error});
        else passes++;
        frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_frame(max_gap);
        @(negedge clk);
        checks++;
        if (wr_addr.size() !== 2)
            $display("FAIL %s_write_count: got %0d required 2", tag, wr_addr.size());
        else passes++;
        checks++;
        if (wr_addr.size() == 2 && ({wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]} !==
                                    {12'd0, 16'h1234, 12'd1, 16'hABCD}))
            $display("FAIL %s_writes: got %0d:%h %0d:%h required 0:1234 1:abcd", tag,
                     wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
        else passes++;
        checks++;
        if ({done, error, cpu_hold, busy} !== 4'b1000 || words_loaded !== 13'd2)
            $display("FAIL %s_final: got done/err/hold/busy=%b words=%0d required 1000 words=2", tag,
                     {done, error, cpu_hold, busy}, words_loaded);
        else passes++;
        checks++;
        if (ready_in_write !== 0)
            $display("FAIL %s_ready_in_write: got %0d cycles required 0", tag, ready_in_write);
        else passes++;
        $display("test_good_load %s done", tag);
    endtask

    task automatic test_bad_csum();
        clear_log();
        pulse_start();
        frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h4B};
        send_frame(0);
        @(negedge clk);
        checks++;
        if (wr_addr.size() !== 2)
            $display("FAIL badcsum_write_count: got %0d required 2", wr_addr.size());
        else passes++;
        checks++;
        if ({done, error, cpu_hold, busy} !== 4'b0110)
            $display("FAIL badcsum_final: got done/err/hold/busy=%b required 0110",
                     {done, error, cpu_hold, busy});
        else passes++;
        $display("test_bad_csum done");
    endtask

    task automatic test_zero_len();
        clear_log();
        pulse_start();
        frame = '{8'h00, 8'h00, 8'h00};
        send_frame(0);
        @(negedge clk);
        checks++;
        if ({done, error, cpu_hold} !== 3'b100 || words_loaded !== 13'd0)
            $display("FAIL zero_final: got done/err/hold=%b words=%0d required 100 words=0",
                     {done, error, cpu_hold}, words_loaded);
        else passes++;
        checks++;
        if (wr_addr.size() !== 0)
            $display("FAIL zero_writes: got %0d required 0", wr_addr.size());
        else passes++;
        $display("test_zero_len done");
    endtask

    task automatic test_oversize();
        clear_log();
        pulse_start();
        frame = '{8'h10, 8'h01};
        send_frame(0);
        checks++;
        if ({error, done, rx_ready, busy, cpu_hold} !== 5'b10001)
            $display("FAIL oversize_state: got err/done/ready/busy/hold=%b required 10001",
                     {error, done, rx_ready, busy, cpu_hold});
        else passes++;
        // A byte offered now must stay unconsumed.
        @(negedge clk);
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (rx_ready !== 1'b0 || error !== 1'b1)
            $display("FAIL oversize_no_ready: got ready=%b err=%b required 0 1", rx_ready, error);
        else passes++;
        rx_valid = 1'b0;
        // Exactly MAX_WORDS is accepted and begins the data phase.
        pulse_start();
        frame = '{8'h10, 8'h00};
        send_frame(0);
        checks++;
        if ({busy, error, rx_ready} !== 3'b101)
            $display("FAIL maxlen_accept: got busy/err/ready=%b required 101", {busy, error, rx_ready});
        else passes++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        $display("test_oversize done");
    endtask

    task automatic test_start_while_busy();
        clear_log();
        pulse_start();
        frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
        send_frame(0);
        pulse_start();   // FSM is in DATA_LO here
        frame = '{8'hCD, 8'h42};
        send_frame(0);
        @(negedge clk);
        checks++;
        if (wr_addr.size() !== 2 || done !== 1'b1 || words_loaded !== 13'd2)
            $display("FAIL busy_start: got writes=%0d done=%b words=%0d required 2 1 2",
                     wr_addr.size(), done, words_loaded);
        else passes++;
        checks++;
        if (wr_addr.size() == 2 && (wr_addr[1] !== 12'd1 || wr_data[1] !== 16'hABCD))
            $display("FAIL busy_start_word: got %0d:%h required 1:abcd", wr_addr[1], wr_data[1]);
        else passes++;
        // Reload after DONE restarts from address 0.
        clear_log();
        pulse_start();
        checks++;
        if ({done, busy} !== 2'b01 || words_loaded !== 13'd0)
            $display("FAIL reload_clear: got done/busy=%b words=%0d required 01 0",
                     {done, busy}, words_loaded);
        else passes++;
        frame = '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h50};
        send_frame(0);
        @(negedge clk);
        checks++;
        if (wr_addr.size() !== 1 || done !== 1'b1 || words_loaded !== 13'd1)
            $display("FAIL reload_done: got writes=%0d done=%b words=%0d required 1 1 1",
                     wr_addr.size(), done, words_loaded);
        else passes++;
        checks++;
        if (wr_addr.size() == 1 && (wr_addr[0] !== 12'd0 || wr_data[0] !== 16'hBEEF))
            $display("FAIL reload_word: got %0d:%h required 0:beef", wr_addr[0], wr_data[0]);
        else passes++;
        $display("test_start_while_busy done");
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        test_reset();
        test_good_load(0, "good");
        test_bad_csum();
        test_zero_len();
        test_oversize();
        test_good_load(3, "gaps");
        test_start_while_busy();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
